// File: rtl/jk_bank_pkg.sv
// Shared types and helpers for the JK bank driver.
// Command opcodes, controller states and the per-bit target-state rule.
package jk_bank_pkg;

    // Retry counter width; MAX_RETRY must fit in it (0..15).
    localparam int unsigned RETRY_W   = 4;
    localparam int unsigned RETRY_MAX = 15;

    typedef enum logic [1:0] {
        OP_LOAD   = 2'b00,
        OP_TOGGLE = 2'b01,
        OP_CLEAR  = 2'b10,
        OP_SET    = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_APPLY = 2'b01,
        ST_CHECK = 2'b10,
        ST_RESP  = 2'b11
    } state_e;

    // Target value of one bank bit given its current value q and command bit d.
    // Applied bit by bit so the helper stays independent of the bank width.
    function automatic logic next_expected(op_e op, logic q, logic d);
        logic e;
        case (op)
            OP_LOAD:   e = d;
            OP_TOGGLE: e = q ^ d;
            OP_CLEAR:  e = q & ~d;
            OP_SET:    e = q | d;
            default:   e = q;
        endcase
        return e;
    endfunction

endpackage

// File: rtl/jk_excitation_calc.sv
// Combinational J/K excitation for a bank of JK flip-flops.
// First attempt follows the command rules; a retry drives LOAD-style toward the expected value.
module jk_excitation_calc
    import jk_bank_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  op_e              op,
    input  logic             retry,
    input  logic [WIDTH-1:0] q,
    input  logic [WIDTH-1:0] d,
    input  logic [WIDTH-1:0] expected,
    output logic [WIDTH-1:0] j,
    output logic [WIDTH-1:0] k
);

    // Per-bit excitation; bits that need no change drive j=k=0 so they hold.
    always_comb begin
        j = '0;
        k = '0;
        if (retry) begin
            j = expected & ~q;
            k = ~expected & q;
        end else begin
            unique case (op)
                OP_LOAD: begin
                    j = d & ~q;
                    k = ~d & q;
                end
                OP_TOGGLE: begin
                    j = d;
                    k = d;
                end
                OP_CLEAR: k = d;
                OP_SET:   j = d;
                default: begin
                    j = '0;
                    k = '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/jk_bank_driver.sv
// Drives a bank of external JK flip-flops to a requested state, verifies and retries.
// Optional statistics counters (cmd_count, err_count) exist when JK_BANK_DRIVER_STATS_EN is
// defined; without it the ports and counters are absent and behaviour is otherwise identical.
module jk_bank_driver
    import jk_bank_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned MAX_RETRY = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_op,
    input  logic [WIDTH-1:0] req_data,
    input  logic [WIDTH-1:0] q_fb,
    output logic [WIDTH-1:0] j_out,
    output logic [WIDTH-1:0] k_out,
    output logic             done,
    output logic             err
`ifdef JK_BANK_DRIVER_STATS_EN
    ,
    output logic [15:0]      cmd_count,
    output logic [7:0]       err_count
`endif
);

    if (MAX_RETRY > RETRY_MAX) begin : g_bad_retry
        $error("MAX_RETRY must be in 0..15");
    end

    localparam logic [RETRY_W-1:0] MaxRetry = RETRY_W'(MAX_RETRY);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   exp_q, exp_d;
    logic [RETRY_W-1:0] retry_q, retry_d;
    logic [WIDTH-1:0]   j_q, j_d, k_q, k_d;
    logic               done_q, done_d, err_q, err_d;

    logic [WIDTH-1:0]   exp_next;
    logic [WIDTH-1:0]   calc_j, calc_k;
    logic               calc_retry;

    // The excitation block is only sampled when leaving IDLE (first attempt) or CHECK (retry).
    assign calc_retry = (state_q == ST_CHECK);

    jk_excitation_calc #(
        .WIDTH (WIDTH)
    ) u_calc (
        .op       (op_e'(req_op)),
        .retry    (calc_retry),
        .q        (q_fb),
        .d        (req_data),
        .expected (exp_q),
        .j        (calc_j),
        .k        (calc_k)
    );

    // Target bank value computed from the live feedback, latched at the accept edge.
    always_comb begin
        exp_next = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            exp_next[i] = next_expected(op_e'(req_op), q_fb[i], req_data[i]);
        end
    end

    // Next-state, latches and registered excitation/response.
    always_comb begin
        state_d = state_q;
        exp_d   = exp_q;
        retry_d = retry_q;
        j_d     = '0;
        k_d     = '0;
        done_d  = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    state_d = ST_APPLY;
                    exp_d   = exp_next;
                    retry_d = '0;
                    j_d     = calc_j;
                    k_d     = calc_k;
                end
            end
            ST_APPLY: state_d = ST_CHECK;
            ST_CHECK: begin
                if (q_fb == exp_q) begin
                    done_d  = 1'b1;
                    state_d = ST_RESP;
                end else if (retry_q < MaxRetry) begin
                    retry_d = retry_q + 1'b1;
                    j_d     = calc_j;
                    k_d     = calc_k;
                    state_d = ST_APPLY;
                end else begin
                    err_d   = 1'b1;
                    state_d = ST_RESP;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // State and output registers; reset drops j/k at once so the bank holds.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            exp_q   <= '0;
            retry_q <= '0;
            j_q     <= '0;
            k_q     <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            exp_q   <= exp_d;
            retry_q <= retry_d;
            j_q     <= j_d;
            k_q     <= k_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign req_ready = (state_q == ST_IDLE);
    assign j_out     = j_q;
    assign k_out     = k_q;
    assign done      = done_q;
    assign err       = err_q;

`ifdef JK_BANK_DRIVER_STATS_EN
    logic [15:0] cmd_count_q;
    logic [7:0]  err_count_q;

    // Counters step together with the done/err pulse; cmd wraps, err saturates.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_count_q <= '0;
            err_count_q <= '0;
        end else begin
            if (done_d) begin
                cmd_count_q <= cmd_count_q + 16'd1;
            end
            if (err_d && (err_count_q != 8'hFF)) begin
                err_count_q <= err_count_q + 8'd1;
            end
        end
    end

    assign cmd_count = cmd_count_q;
    assign err_count = err_count_q;
`endif

endmodule

// File: tb/tb_jk_bank_driver.sv
// Self-checking bench for jk_bank_driver with a behavioural JK bank and a
// transaction-level reference model. Build with JK_BANK_DRIVER_STATS_EN to cover the counters.
module tb_jk_bank_driver;

    localparam int unsigned WIDTH     = 8;
    localparam int unsigned MAX_RETRY = 2;

    typedef struct packed {
        logic       ready;
        logic [7:0] j;
        logic [7:0] k;
        logic       done;
        logic       err;
    } cyc_t;

    localparam cyc_t IdleCyc = '{ready: 1'b1, j: 8'h00, k: 8'h00, done: 1'b0, err: 1'b0};

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req_valid;
    logic       req_ready;
    logic [1:0] req_op;
    logic [7:0] req_data;
    logic [7:0] q_fb;
    logic [7:0] j_out, k_out;
    logic       done, err;
    logic [7:0] bank = 8'h00;
    logic [7:0] stuck = 8'h00;
`ifdef JK_BANK_DRIVER_STATS_EN
    logic [15:0] cmd_count;
    logic [7:0]  err_count;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    cyc_t        exp_q[$];
    logic [15:0] m_cmd = 16'd0;
    logic [7:0]  m_err = 8'd0;

    always #5 clk = ~clk;

    jk_bank_driver #(
        .WIDTH     (WIDTH),
        .MAX_RETRY (MAX_RETRY)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_data  (req_data),
        .q_fb      (q_fb),
        .j_out     (j_out),
        .k_out     (k_out),
        .done      (done),
        .err       (err)
`ifdef JK_BANK_DRIVER_STATS_EN
        ,
        .cmd_count (cmd_count),
        .err_count (err_count)
`endif
    );

    // JK characteristic equation: Q+ = J~Q | ~K Q.
    function automatic logic [7:0] jk_next(logic [7:0] q, logic [7:0] j, logic [7:0] k);
        return (j & ~q) | (~k & q);
    endfunction

    // External bank; stuck bits read back as 0 regardless of the flop.
    always @(posedge clk) bank <= jk_next(bank, j_out, k_out);
    assign q_fb = bank & ~stuck;

    function automatic void check(string name, logic [31:0] act, logic [31:0] want);
        n_tests++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, want, $time);
        end
    endfunction

    function automatic logic [7:0] target(logic [1:0] op, logic [7:0] q, logic [7:0] d);
        case (op)
            2'd0:    return d;
            2'd1:    return q ^ d;
            2'd2:    return q & ~d;
            default: return q | d;
        endcase
    endfunction

    // Expand one accepted command into its expected cycle-by-cycle output trace.
    function automatic void build(logic [1:0] op, logic [7:0] d, logic [7:0] qv,
                                  logic [7:0] bnk, logic [7:0] stk);
        logic [7:0] e, j, k, b, vis;
        int         tries;
        e = target(op, qv, d);
        case (op)
            2'd0:    begin j = d & ~qv; k = ~d & qv; end
            2'd1:    begin j = d;       k = d;       end
            2'd2:    begin j = 8'h00;   k = d;       end
            default: begin j = d;       k = 8'h00;   end
        endcase
        b = bnk;
        tries = 0;
        forever begin
            exp_q.push_back('{ready: 1'b0, j: j, k: k, done: 1'b0, err: 1'b0});
            b = jk_next(b, j, k);
            vis = b & ~stk;
            exp_q.push_back('{ready: 1'b0, j: 8'h00, k: 8'h00, done: 1'b0, err: 1'b0});
            if (vis == e) begin
                exp_q.push_back('{ready: 1'b0, j: 8'h00, k: 8'h00, done: 1'b1, err: 1'b0});
                break;
            end else if (tries < MAX_RETRY) begin
                tries++;
                j = e & ~vis;
                k = ~e & vis;
            end else begin
                exp_q.push_back('{ready: 1'b0, j: 8'h00, k: 8'h00, done: 1'b0, err: 1'b1});
                break;
            end
        end
    endfunction

    // Reference model: accept when idle, otherwise step through the expected trace.
    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                exp_q.delete();
                m_cmd = 16'd0;
                m_err = 8'd0;
            end else begin
                if (exp_q.size() == 0) begin
                    if (req_valid) build(req_op, req_data, q_fb, bank, stuck);
                end else begin
                    void'(exp_q.pop_front());
                end
                if (exp_q.size() != 0) begin
                    if (exp_q[0].done) m_cmd = m_cmd + 16'd1;
                    if (exp_q[0].err && m_err != 8'hFF) m_err = m_err + 8'd1;
                end
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    initial begin
        cyc_t e;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                e = (exp_q.size() != 0) ? exp_q[0] : IdleCyc;
                check("cyc_ready", 32'(req_ready), 32'(e.ready));
                check("cyc_j", 32'(j_out), 32'(e.j));
                check("cyc_k", 32'(k_out), 32'(e.k));
                check("cyc_done", 32'(done), 32'(e.done));
                check("cyc_err", 32'(err), 32'(e.err));
`ifdef JK_BANK_DRIVER_STATS_EN
                check("cyc_cmd_count", 32'(cmd_count), 32'(m_cmd));
                check("cyc_err_count", 32'(err_count), 32'(m_err));
`endif
            end
        end
    end

    task automatic issue(input logic [1:0] op, input logic [7:0] data,
                         output logic [7:0] fj, output logic [7:0] fk,
                         output int edges, output int applies,
                         output logic got_done, output logic got_err, output logic rdy_pulse);
        int t;
        t = 0;
        while (!req_ready && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        if (!req_ready) check("ready_timeout", 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_op    = op;
        req_data  = data;
        @(posedge clk); #1;
        req_valid = 1'b0;
        fj = j_out;
        fk = k_out;
        edges = 1;
        applies = 0;
        while (!done && !err && edges < 40) begin
            if ((j_out | k_out) != 8'h00) applies++;
            @(posedge clk); #1;
            edges++;
        end
        got_done  = done;
        got_err   = err;
        rdy_pulse = req_ready;
    endtask

    initial begin
        logic [7:0] fj, fk;
        int         edges, applies, t;
        logic       gd, ge, rp;

        req_valid = 1'b0;
        req_op    = 2'b00;
        req_data  = 8'h00;

        // Reset state
        #1;
        check("rst_ready", 32'(req_ready), 32'd1);
        check("rst_j", 32'(j_out), 32'd0);
        check("rst_k", 32'(k_out), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;

        // 1: LOAD 0xA5 onto an empty bank
        issue(2'd0, 8'hA5, fj, fk, edges, applies, gd, ge, rp);
        check("t1_j", 32'(fj), 32'hA5);
        check("t1_k", 32'(fk), 32'h00);
        check("t1_latency", 32'(edges), 32'd3);
        check("t1_done", 32'(gd), 32'd1);
        check("t1_ready_at_pulse", 32'(rp), 32'd0);
        check("t1_bank", 32'(q_fb), 32'hA5);

        // 2: TOGGLE, CLEAR, SET chain
        issue(2'd1, 8'h0F, fj, fk, edges, applies, gd, ge, rp);
        check("t2_tog_j", 32'(fj), 32'h0F);
        check("t2_tog_k", 32'(fk), 32'h0F);
        check("t2_tog_bank", 32'(q_fb), 32'hAA);
        check("t2_tog_done", 32'(gd), 32'd1);
        issue(2'd2, 8'h80, fj, fk, edges, applies, gd, ge, rp);
        check("t2_clr_j", 32'(fj), 32'h00);
        check("t2_clr_k", 32'(fk), 32'h80);
        check("t2_clr_bank", 32'(q_fb), 32'h2A);
        issue(2'd3, 8'h01, fj, fk, edges, applies, gd, ge, rp);
        check("t2_set_j", 32'(fj), 32'h01);
        check("t2_set_k", 32'(fk), 32'h00);
        check("t2_set_bank", 32'(q_fb), 32'h2B);
        check("t2_set_done", 32'(gd), 32'd1);

        // 3: bit0 stuck at 0, LOAD 0x01 exhausts retries
        @(posedge clk); #1;
        stuck = 8'h01;
        issue(2'd0, 8'h01, fj, fk, edges, applies, gd, ge, rp);
        check("t3_applies", 32'(applies), 32'd3);
        check("t3_edges", 32'(edges), 32'd7);
        check("t3_err", 32'(ge), 32'd1);
        check("t3_done", 32'(gd), 32'd0);
`ifdef JK_BANK_DRIVER_STATS_EN
        check("t3_cmd_count", 32'(cmd_count), 32'd4);
        check("t3_err_count", 32'(err_count), 32'd1);
`endif
        @(posedge clk); #1;
        stuck = 8'h00;

        // 4: req_valid held through busy with different data
        req_valid = 1'b1;
        req_op    = 2'd0;
        req_data  = 8'h3C;
        @(posedge clk); #1;
        req_op   = 2'd3;
        req_data = 8'hFF;
        t = 0;
        while (!done && !err && t < 20) begin
            check("t4_busy_ready", 32'(req_ready), 32'd0);
            @(posedge clk); #1;
            t++;
        end
        check("t4_done", 32'(done), 32'd1);
        check("t4_ready_at_pulse", 32'(req_ready), 32'd0);
        check("t4_bank", 32'(q_fb), 32'h3C);
        req_valid = 1'b0;
        @(posedge clk); #1;
        check("t4_ready_after", 32'(req_ready), 32'd1);

        // 5: asynchronous reset during APPLY
        req_valid = 1'b1;
        req_op    = 2'd0;
        req_data  = 8'hC3;
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("t5_apply_j", 32'(j_out), 32'hC3);
        check("t5_apply_k", 32'(k_out), 32'h3C);
        #1 rst_n = 1'b0;
        #1;
        check("t5_rst_j", 32'(j_out), 32'd0);
        check("t5_rst_k", 32'(k_out), 32'd0);
        check("t5_rst_ready", 32'(req_ready), 32'd1);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check("t5_no_done", 32'(done), 32'd0);
            check("t5_no_err", 32'(err), 32'd0);
        end
        check("t5_ready", 32'(req_ready), 32'd1);
        check("t5_bank_held", 32'(q_fb), 32'h3C);

        // Randomized traffic, occasionally with a stuck bit
        for (int i = 0; i < 600; i++) begin
            @(posedge clk); #1;
            req_valid = ($urandom_range(0, 2) != 0);
            req_op    = 2'($urandom_range(0, 3));
            req_data  = 8'($urandom);
            if (req_ready && $urandom_range(0, 9) == 0) begin
                stuck = ($urandom_range(0, 1) != 0) ? 8'(1 << $urandom_range(0, 7)) : 8'h00;
            end
        end
        req_valid = 1'b0;
        t = 0;
        while (!req_ready && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        if (!req_ready) check("final_ready_timeout", 32'(req_ready), 32'd1);
        repeat (3) @(posedge clk);
        #1;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
